prod_sum_accum: RTL and testbench
=================================

// Module: prod_sum_accum
// PURPOSE
//  Downstream stage of the pipelined product-sum unit. Tracks beats issued into the
//  product-sum pipe, catches each pipe_sum when it emerges, and accumulates the sums of one
//  vector (beats up to in_last) into a wide result. The result is presented through a
//  one-entry valid/ready output register, and the block drives the pipe enable to stall on backpressure.
// PARAMETERS
//  SUM_WIDTH   4   width of pipe_sum; equals the product-sum pipe sum width
//  NUM_STAGES  2   product-sum pipe stages (>=1); issue-to-pipe_sum latency = NUM_STAGES-1 enabled cycles
//  ACC_WIDTH   16  accumulator/result width (> SUM_WIDTH)
//  CNT_WIDTH   8   beat counter width
//  SAT_MODE    1   1 = saturate result on overflow; 0 = wrap modulo 2^ACC_WIDTH
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous reset, active low; also drives the pipe's rst_n
//  in_valid   in   1          operand beat presented to the pipe a/b inputs this cycle
//  in_last    in   1          beat is the final one of the vector
//  in_tc      in   1          1 = two's complement beat, 0 = unsigned; also drives the pipe tc
//  in_ready   out  1          beat accepted when in_valid & in_ready
//  pipe_en    out  1          enable to the product-sum pipe (stall_mode 1)
//  pipe_sum   in   SUM_WIDTH  sum output of the product-sum pipe
//  acc_valid  out  1          result register holds a vector result
//  acc_ready  in   1          consumer takes result when acc_valid & acc_ready
//  acc_data   out  ACC_WIDTH  accumulated (saturated or wrapped) vector result
//  acc_ovf    out  1          overflow occurred at some point in this vector
//  acc_beats  out  CNT_WIDTH  beats in this vector; saturates at all-ones
// BEHAVIOUR
//  - Reset: acc_valid=0, acc_data=0, acc_ovf=0, acc_beats=0; accumulator, beat count, and all tokens cleared.
//  - stall = acc_valid & ~acc_ready; pipe_en = in_ready = ~stall (combinational).
//  - Token {vld,last,tc} enters the delay line on issue (in_valid & in_ready). The line advances
//    only when pipe_en=1 and has depth NUM_STAGES-1; NUM_STAGES=1 means exit token = issue token, same cycle.
//  - Stalled (pipe_en=0): tokens, accumulator, and count hold; in_valid is ignored and no beat is lost.
//  - Exit token vld & pipe_en: ext = sign-extend(pipe_sum) if tok.tc, else zero-extend;
//    nxt = acc + ext in ACC_WIDTH+1 bits. Overflow = signed out-of-range (tc) or carry out (unsigned).
//    Overflow sets the sticky ovf. If SAT_MODE=1, clamp to max/min of the tok.tc range; else keep low bits.
//  - Exit token not last: acc<=nxt, cnt++ (saturating).
//  - Exit token last: result register <= {nxt, ovf|this_ovf, cnt+1}, acc_valid<=1;
//    accumulator, ovf, and cnt are cleared the same cycle.
//  - Pop and load in the same cycle (acc_valid & acc_ready with a last token exiting): the new result loads and acc_valid stays 1.
//  - Exit token invalid: acc, cnt, and ovf hold; pipe_sum is ignored.
//  - in_tc is constant within a vector. If it changes mid-vector, each beat is extended with its
//    own tc, and the last beat's tc selects the saturation range.
//  - Throughput: one beat per cycle with no backpressure. Vectors are back-to-back and need no gap cycle.
//  - Reset mid-vector or mid-stall: everything in flight is discarded, and nothing is emitted after reset.
// STRUCTURE
//  - prod_sum_accum_pkg: typedef tok_t {vld,last,tc}; functions sat_max(tc), sat_min(tc), ext_sum(sum,tc).
//  - Sub-module prod_sum_tok_line: enable-gated token delay line of depth NUM_STAGES-1, async reset,
//    with a generate bypass when the depth is 0.
//  - Top level: stall logic, adder with saturation, accumulator/count registers, result register.
// TESTING (bench pairs this block with a DW_prod_sum_pipe model, SUM_WIDTH=4, NUM_STAGES=2, ACC_WIDTH=16)
//  1. Unsigned 3-beat vector, sums 5,7,15, acc_ready=1 -> one acc_valid pulse, data=27, beats=3, ovf=0,
//     2 cycles after the last beat issues.
//  2. Signed vector, sums -8,+3,-1 (tc=1) -> data=16'hFFFA (-6), ovf=0.
//  3. SAT_MODE=1, ACC_WIDTH=6, signed: 5 beats of +7 -> data=31, ovf=1.
//     SAT_MODE=0, same stimulus -> data=-29 (35 mod 64), ovf=1.
//  4. Backpressure: result pending with acc_ready=0 for 4 cycles while in_valid=1 -> pipe_en=in_ready=0 and
//     no beat accepted. On release, the next vector still accumulates correctly with no beat lost or duplicated.
//  5. Back-to-back 1-beat vectors, sums 1,2,3 with acc_ready=1 -> results 1,2,3 on consecutive cycles.
//  6. rst_n asserted mid-vector and during a stall -> all outputs 0 at once (asynchronous).
//     A post-reset 2-beat vector of 4,4 -> data=8, beats=2.

Source files
------------

// File: rtl/prod_sum_accum_pkg.sv
// Shared types and helpers for the product-sum accumulator stage.
package prod_sum_accum_pkg;

  // Widest operand the helpers handle; callers size-cast results down.
  localparam int unsigned MaxW = 64;

  typedef struct packed {
    logic vld;
    logic last;
    logic tc;
  } tok_t;

  function automatic logic [MaxW-1:0] low_mask(input int unsigned w);
    return (MaxW'(1) << w) - MaxW'(1);
  endfunction

  // Largest representable value in a w-bit field, signed or unsigned.
  function automatic logic [MaxW-1:0] sat_max(input logic tc, input int unsigned w);
    return tc ? low_mask(w - 1) : low_mask(w);
  endfunction

  // Smallest representable value in a w-bit field, as a w-bit pattern.
  function automatic logic [MaxW-1:0] sat_min(input logic tc, input int unsigned w);
    return tc ? (MaxW'(1) << (w - 1)) : '0;
  endfunction

  // Sign- or zero-extend the low w bits of sum.
  function automatic logic [MaxW-1:0] ext_sum(input logic [MaxW-1:0] sum, input int unsigned w,
                                              input logic tc);
    logic sgn;
    sgn = tc & (|(sum & (MaxW'(1) << (w - 1))));
    return (sum & low_mask(w)) | (sgn ? ~low_mask(w) : '0);
  endfunction

endpackage

// File: rtl/prod_sum_tok_line.sv
// Enable-gated delay line that tracks beat tokens alongside the product-sum pipe.
module prod_sum_tok_line
  import prod_sum_accum_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  tok_t tok_in,
  output tok_t tok_out
);

  if (DEPTH == 0) begin : g_bypass
    assign tok_out = tok_in;
  end else if (DEPTH == 1) begin : g_single
    tok_t line_q;
    // Single stage advances only while the pipe is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        line_q <= '0;
      end else if (en) begin
        line_q <= tok_in;
      end
    end
    assign tok_out = line_q;
  end else begin : g_multi
    tok_t [DEPTH-1:0] line_q;
    // Shift register advances only while the pipe is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        line_q <= '0;
      end else if (en) begin
        line_q <= {line_q[DEPTH-2:0], tok_in};
      end
    end
    assign tok_out = line_q[DEPTH-1];
  end

endmodule

// File: rtl/prod_sum_accum.sv
// Accumulates product-sum pipe outputs per vector into a wide result with a
// one-entry valid/ready output register; stalls the pipe on backpressure.
module prod_sum_accum
  import prod_sum_accum_pkg::*;
#(
  parameter int unsigned SUM_WIDTH  = 4,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned SAT_MODE   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 in_tc,
  output logic                 in_ready,
  output logic                 pipe_en,
  input  logic [SUM_WIDTH-1:0] pipe_sum,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc_data,
  output logic                 acc_ovf,
  output logic [CNT_WIDTH-1:0] acc_beats
);

  logic                 stall;
  tok_t                 tok_in, tok_out;
  logic                 fire;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, ext, sum_val;
  logic [ACC_WIDTH:0]   acc_x, ext_x, nxt;
  logic                 this_ovf;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 ovf_q, ovf_d;
  logic                 res_valid_q, res_valid_d;
  logic [ACC_WIDTH-1:0] res_data_q, res_data_d;
  logic                 res_ovf_q, res_ovf_d;
  logic [CNT_WIDTH-1:0] res_beats_q, res_beats_d;

  assign stall    = res_valid_q & ~acc_ready;
  assign pipe_en  = ~stall;
  assign in_ready = ~stall;
  assign tok_in   = {in_valid & in_ready, in_last, in_tc};
  assign fire     = tok_out.vld & pipe_en;

  prod_sum_tok_line #(
    .DEPTH(NUM_STAGES - 1)
  ) u_tok_line (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pipe_en),
    .tok_in (tok_in),
    .tok_out(tok_out)
  );

  // Extend the emerging sum, add one guard bit, detect overflow and clamp.
  always_comb begin
    ext      = ACC_WIDTH'(ext_sum(MaxW'(pipe_sum), SUM_WIDTH, tok_out.tc));
    acc_x    = {tok_out.tc & acc_q[ACC_WIDTH-1], acc_q};
    ext_x    = {tok_out.tc & ext[ACC_WIDTH-1], ext};
    nxt      = acc_x + ext_x;
    this_ovf = tok_out.tc ? (nxt[ACC_WIDTH] ^ nxt[ACC_WIDTH-1]) : nxt[ACC_WIDTH];
    sum_val  = nxt[ACC_WIDTH-1:0];
    if ((SAT_MODE != 0) && this_ovf) begin
      // Guard bit is the true sign for signed; unsigned can only overflow upward.
      sum_val = (tok_out.tc && nxt[ACC_WIDTH]) ? ACC_WIDTH'(sat_min(1'b1, ACC_WIDTH))
                                               : ACC_WIDTH'(sat_max(tok_out.tc, ACC_WIDTH));
    end
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  end

  // Next state for accumulator, beat count and the output register.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_beats_d = res_beats_q;
    if (res_valid_q && acc_ready) begin
      res_valid_d = 1'b0;
    end
    if (fire) begin
      if (tok_out.last) begin
        res_valid_d = 1'b1;
        res_data_d  = sum_val;
        res_ovf_d   = ovf_q | this_ovf;
        res_beats_d = cnt_inc;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum_val;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | this_ovf;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_beats_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_beats_q <= res_beats_d;
    end
  end

  assign acc_valid = res_valid_q;
  assign acc_data  = res_data_q;
  assign acc_ovf   = res_ovf_q;
  assign acc_beats = res_beats_q;

endmodule

// File: tb/tb_prod_sum_accum.sv
// Directed bench: main 16-bit instance plus two 6-bit instances (saturate / wrap),
// each paired with a one-register product-sum pipe model (NUM_STAGES=2).
module tb_prod_sum_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_last, in_tc, acc_ready;
  logic [3:0]  sum_in;

  logic        in_ready, pipe_en, acc_valid, acc_ovf;
  logic [3:0]  pipe_sum;
  logic [15:0] acc_data;
  logic [7:0]  acc_beats;

  logic        s_in_ready, s_pipe_en, s_acc_valid, s_acc_ovf;
  logic [3:0]  s_pipe_sum;
  logic [5:0]  s_acc_data;
  logic [7:0]  s_acc_beats;

  logic        w_in_ready, w_pipe_en, w_acc_valid, w_acc_ovf;
  logic [3:0]  w_pipe_sum;
  logic [5:0]  w_acc_data;
  logic [7:0]  w_acc_beats;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prod_sum_accum #(
    .SUM_WIDTH(4), .NUM_STAGES(2), .ACC_WIDTH(16), .CNT_WIDTH(8), .SAT_MODE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_tc(in_tc),
    .in_ready(in_ready), .pipe_en(pipe_en), .pipe_sum(pipe_sum), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .acc_data(acc_data), .acc_ovf(acc_ovf), .acc_beats(acc_beats)
  );

  prod_sum_accum #(
    .SUM_WIDTH(4), .NUM_STAGES(2), .ACC_WIDTH(6), .CNT_WIDTH(8), .SAT_MODE(1)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_tc(in_tc),
    .in_ready(s_in_ready), .pipe_en(s_pipe_en), .pipe_sum(s_pipe_sum), .acc_valid(s_acc_valid),
    .acc_ready(1'b1), .acc_data(s_acc_data), .acc_ovf(s_acc_ovf), .acc_beats(s_acc_beats)
  );

  prod_sum_accum #(
    .SUM_WIDTH(4), .NUM_STAGES(2), .ACC_WIDTH(6), .CNT_WIDTH(8), .SAT_MODE(0)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_tc(in_tc),
    .in_ready(w_in_ready), .pipe_en(w_pipe_en), .pipe_sum(w_pipe_sum), .acc_valid(w_acc_valid),
    .acc_ready(1'b1), .acc_data(w_acc_data), .acc_ovf(w_acc_ovf), .acc_beats(w_acc_beats)
  );

  // Product-sum pipe models: one enabled register stage each.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_sum <= '0;
    else if (pipe_en) pipe_sum <= sum_in;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_pipe_sum <= '0;
    else if (s_pipe_en) s_pipe_sum <= sum_in;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_pipe_sum <= '0;
    else if (w_pipe_en) w_pipe_sum <= sum_in;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [3:0] s, input logic tc, input logic last);
    in_valid = 1'b1;
    sum_in   = s;
    in_tc    = tc;
    in_last  = last;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; in_last = 1'b0; in_tc = 1'b0; sum_in = '0; acc_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(acc_valid), 32'd0);
    check_eq("rst_data", 32'(acc_data), 32'd0);
    check_eq("rst_ovf", 32'(acc_ovf), 32'd0);
    check_eq("rst_beats", 32'(acc_beats), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    idle();

    // 1: unsigned 5+7+15
    beat(4'd5, 1'b0, 1'b0);
    beat(4'd7, 1'b0, 1'b0);
    beat(4'd15, 1'b0, 1'b1);
    check_eq("t1_early_valid", 32'(acc_valid), 32'd0);
    idle();
    check_eq("t1_valid", 32'(acc_valid), 32'd1);
    check_eq("t1_data", 32'(acc_data), 32'd27);
    check_eq("t1_beats", 32'(acc_beats), 32'd3);
    check_eq("t1_ovf", 32'(acc_ovf), 32'd0);
    idle();
    check_eq("t1_pulse_end", 32'(acc_valid), 32'd0);

    // 2: signed -8+3-1
    beat(4'h8, 1'b1, 1'b0);
    beat(4'h3, 1'b1, 1'b0);
    beat(4'hF, 1'b1, 1'b1);
    idle();
    check_eq("t2_valid", 32'(acc_valid), 32'd1);
    check_eq("t2_data", 32'(acc_data), 32'h0000_FFFA);
    check_eq("t2_ovf", 32'(acc_ovf), 32'd0);
    idle();

    // 3: five +7 beats signed into 6 bits
    repeat (4) beat(4'd7, 1'b1, 1'b0);
    beat(4'd7, 1'b1, 1'b1);
    idle();
    check_eq("t3_sat_valid", 32'(s_acc_valid), 32'd1);
    check_eq("t3_sat_data", 32'(s_acc_data), 32'd31);
    check_eq("t3_sat_ovf", 32'(s_acc_ovf), 32'd1);
    check_eq("t3_sat_beats", 32'(s_acc_beats), 32'd5);
    check_eq("t3_wrap_data", 32'(w_acc_data), 32'h23);
    check_eq("t3_wrap_ovf", 32'(w_acc_ovf), 32'd1);
    check_eq("t3_wrap_valid", 32'(w_acc_valid), 32'd1);
    check_eq("t3_main_data", 32'(acc_data), 32'd35);
    check_eq("t3_main_ovf", 32'(acc_ovf), 32'd0);
    idle();

    // 4: backpressure
    acc_ready = 1'b0;
    beat(4'd3, 1'b0, 1'b1);
    idle();
    check_eq("t4_valid", 32'(acc_valid), 32'd1);
    check_eq("t4_data", 32'(acc_data), 32'd3);
    check_eq("t4_pipe_en", 32'(pipe_en), 32'd0);
    in_valid = 1'b1; sum_in = 4'd9; in_last = 1'b0; in_tc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("t4_stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("t4_stall_pipe_en", 32'(pipe_en), 32'd0);
      check_eq("t4_stall_data", 32'(acc_data), 32'd3);
    end
    acc_ready = 1'b1;
    #1;
    check_eq("t4_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check_eq("t4_popped", 32'(acc_valid), 32'd0);
    beat(4'd6, 1'b0, 1'b1);
    idle();
    check_eq("t4_next_valid", 32'(acc_valid), 32'd1);
    check_eq("t4_next_data", 32'(acc_data), 32'd15);
    check_eq("t4_next_beats", 32'(acc_beats), 32'd2);
    idle();

    // 5: back-to-back 1-beat vectors
    beat(4'd1, 1'b0, 1'b1);
    check_eq("t5_none", 32'(acc_valid), 32'd0);
    beat(4'd2, 1'b0, 1'b1);
    check_eq("t5_r1", 32'(acc_data), 32'd1);
    check_eq("t5_v1", 32'(acc_valid), 32'd1);
    beat(4'd3, 1'b0, 1'b1);
    check_eq("t5_r2", 32'(acc_data), 32'd2);
    check_eq("t5_v2", 32'(acc_valid), 32'd1);
    idle();
    check_eq("t5_r3", 32'(acc_data), 32'd3);
    check_eq("t5_b3", 32'(acc_beats), 32'd1);
    idle();
    check_eq("t5_end", 32'(acc_valid), 32'd0);

    // 6: asynchronous reset mid-vector during a stall
    acc_ready = 1'b0;
    beat(4'd2, 1'b0, 1'b1);
    beat(4'd4, 1'b0, 1'b0);
    idle();
    check_eq("t6_pre_valid", 32'(acc_valid), 32'd1);
    check_eq("t6_pre_stall", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(acc_valid), 32'd0);
    check_eq("t6_rst_data", 32'(acc_data), 32'd0);
    check_eq("t6_rst_beats", 32'(acc_beats), 32'd0);
    check_eq("t6_rst_ovf", 32'(acc_ovf), 32'd0);
    check_eq("t6_rst_ready", 32'(in_ready), 32'd1);
    acc_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    idle();
    check_eq("t6_quiet", 32'(acc_valid), 32'd0);
    beat(4'd4, 1'b0, 1'b0);
    beat(4'd4, 1'b0, 1'b1);
    idle();
    check_eq("t6_valid", 32'(acc_valid), 32'd1);
    check_eq("t6_data", 32'(acc_data), 32'd8);
    check_eq("t6_beats", 32'(acc_beats), 32'd2);
    check_eq("t6_sat_ready", 32'(s_in_ready & w_in_ready), 32'd1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
